// File: rtl/pinmux_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pinmux_pkg
// Brief   : Shared state encoding and default sizing for the pad-select control.
// Revision: 1.0 - initial release
// ============================================================================
package pinmux_pkg;

    localparam int DEF_NUM_PERIPHERALS = 4;
    localparam int DEF_SEL_WIDTH       = 5;
    localparam int DEF_GUARD_CYCLES    = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GUARD  = 3'd1,
        ST_SELECT = 3'd2,
        ST_OWNED  = 3'd3,
        ST_DRAIN  = 3'd4
    } pinmux_state_e;

endpackage
`default_nettype wire

// File: rtl/pinmux_rr_arb.sv
`default_nettype none
// ============================================================================
// Module  : pinmux_rr_arb
// Brief   : Combinational round-robin pick among eligible requesters, one-hot out.
// Revision: 1.0 - initial release
// ============================================================================
module pinmux_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_mask,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt
);

    logic [NUM_REQ-1:0] w_cand;
    logic               w_found;
    int                 w_idx;

    assign w_cand = i_req & i_mask;

    // Scan starting at the pointer and wrapping; the first candidate wins.
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(i_ptr) + k) % NUM_REQ;
            if (!w_found && w_cand[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pinmux_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pinmux_sel_ctrl
// Brief   : Break-before-make pad ownership controller with guard interval.
//           Optional owner lock input enabled by defining PINMUX_LOCK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module pinmux_sel_ctrl
    import pinmux_pkg::*;
#(
    parameter int NUM_PERIPHERALS = DEF_NUM_PERIPHERALS,
    parameter int SEL_WIDTH       = DEF_SEL_WIDTH,
    parameter int GUARD_CYCLES    = DEF_GUARD_CYCLES
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_PERIPHERALS-1:0] i_req,
`ifdef PINMUX_LOCK_EN
    input  logic                       i_lock,
`endif
    output logic [NUM_PERIPHERALS-1:0] o_grant,
    output logic [SEL_WIDTH-1:0]       o_sel,
    output logic                       o_oe_en,
    output logic                       o_busy
);

    localparam int PTR_W = (NUM_PERIPHERALS > 1) ? $clog2(NUM_PERIPHERALS) : 1;
    localparam int CNT_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_guard_load = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [PTR_W-1:0] c_last_idx   = PTR_W'(NUM_PERIPHERALS - 1);

    pinmux_state_e              r_state, w_state_nxt;
    logic [CNT_W-1:0]           r_cnt, w_cnt_nxt;
    logic [PTR_W-1:0]           r_ptr, w_ptr_nxt;
    logic [PTR_W-1:0]           r_win_idx, w_win_idx_nxt;
    logic [NUM_PERIPHERALS-1:0] r_win_oh, w_win_oh_nxt;

    logic [NUM_PERIPHERALS-1:0] w_elig;
    logic [NUM_PERIPHERALS-1:0] w_arb_oh;
    logic [PTR_W-1:0]           w_arb_idx;
    logic [SEL_WIDTH-1:0]       w_sel_oh;
    logic                       w_owner_req;
    logic                       w_lock;

`ifdef PINMUX_LOCK_EN
    assign w_lock = i_lock;
`else
    assign w_lock = 1'b0;
`endif

    // Requesters without a select line can never own the pad.
    for (genvar i = 0; i < NUM_PERIPHERALS; i++) begin : g_elig
        if (i < SEL_WIDTH) begin : g_on
            assign w_elig[i] = 1'b1;
        end else begin : g_off
            assign w_elig[i] = 1'b0;
        end
    end

    for (genvar j = 0; j < SEL_WIDTH; j++) begin : g_sel
        if (j < NUM_PERIPHERALS) begin : g_map
            assign w_sel_oh[j] = r_win_oh[j];
        end else begin : g_zero
            assign w_sel_oh[j] = 1'b0;
        end
    end

    pinmux_rr_arb #(
        .NUM_REQ (NUM_PERIPHERALS),
        .PTR_W   (PTR_W)
    ) u_arb (
        .i_req  (i_req),
        .i_mask (w_elig),
        .i_ptr  (r_ptr),
        .o_gnt  (w_arb_oh)
    );

    always_comb begin
        w_arb_idx = '0;
        for (int i = 0; i < NUM_PERIPHERALS; i++) begin
            if (w_arb_oh[i]) begin
                w_arb_idx = PTR_W'(i);
            end
        end
    end

    assign w_owner_req = |(i_req & r_win_oh);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_ptr     <= '0;
            r_win_idx <= '0;
            r_win_oh  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ptr     <= w_ptr_nxt;
            r_win_idx <= w_win_idx_nxt;
            r_win_oh  <= w_win_oh_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_ptr_nxt     = r_ptr;
        w_win_idx_nxt = r_win_idx;
        w_win_oh_nxt  = r_win_oh;
        o_grant       = '0;
        o_sel         = '0;
        o_oe_en       = 1'b0;
        o_busy        = 1'b1;

        case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (!w_lock && (|w_arb_oh)) begin
                    w_win_oh_nxt  = w_arb_oh;
                    w_win_idx_nxt = w_arb_idx;
                    w_cnt_nxt     = c_guard_load;
                    w_state_nxt   = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (!w_owner_req) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_SELECT;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_SELECT: begin
                o_sel = w_sel_oh;
                if (!w_owner_req) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_OWNED;
                    w_ptr_nxt   = (r_win_idx == c_last_idx) ? '0 : r_win_idx + 1'b1;
                end
            end
            ST_OWNED: begin
                o_sel   = w_sel_oh;
                o_grant = r_win_oh;
                o_oe_en = 1'b1;
                if (!w_owner_req && !w_lock) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Select stays put one more cycle so OE is already low when it moves.
                o_sel       = w_sel_oh;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_pinmux_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pinmux_sel_ctrl
// Brief   : Randomized scoreboard bench for pinmux_sel_ctrl (6 requesters, 5 selects).
// Revision: 1.0 - initial release
// ============================================================================
module tb_pinmux_sel_ctrl;

    localparam int N  = 6;
    localparam int SW = 5;
    localparam int G  = 2;
    localparam int OW = SW + N + 2;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req;
    logic          lock;
    logic [N-1:0]  grant;
    logic [SW-1:0] sel;
    logic          oe_en;
    logic          busy;

    int tests;
    int failed;
    int cyc;

    logic [OW-1:0] exp_q[$];

    // Reference model: ownership as an age counted in edges since the win.
    bit m_active;
    bit m_drain;
    int m_owner;
    int m_age;
    int m_ptr;

    pinmux_sel_ctrl #(
        .NUM_PERIPHERALS (N),
        .SEL_WIDTH       (SW),
        .GUARD_CYCLES    (G)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_req   (req),
`ifdef PINMUX_LOCK_EN
        .i_lock  (lock),
`endif
        .o_grant (grant),
        .o_sel   (sel),
        .o_oe_en (oe_en),
        .o_busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_active = 1'b0;
        m_drain  = 1'b0;
        m_owner  = 0;
        m_age    = 0;
        m_ptr    = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic l);
        if (m_drain) begin
            m_drain  = 1'b0;
            m_active = 1'b0;
        end else if (!m_active) begin
            if (!l) begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_ptr + k) % N;
                    if (!m_active && r[idx] && idx < SW) begin
                        m_active = 1'b1;
                        m_owner  = idx;
                        m_age    = 1;
                    end
                end
            end
        end else if (m_age < G + 2) begin
            if (!r[m_owner]) begin
                m_active = 1'b0;
            end else begin
                m_age = m_age + 1;
                if (m_age == G + 2) m_ptr = (m_owner + 1) % N;
            end
        end else begin
            if (!r[m_owner] && !l) m_drain = 1'b1;
        end
    endtask

    function automatic logic [OW-1:0] model_out();
        logic [N-1:0]  oh;
        logic [SW-1:0] s;
        logic [N-1:0]  g;
        logic          o;
        oh = '0;
        s  = '0;
        g  = '0;
        o  = 1'b0;
        if (!m_active) return '0;
        oh[m_owner] = 1'b1;
        if (m_drain || m_age >= G + 1) s = oh[SW-1:0];
        if (!m_drain && m_age >= G + 2) begin
            g = oh;
            o = 1'b1;
        end
        return {s, g, o, 1'b1};
    endfunction

    task automatic tick(input logic [N-1:0] r, input logic l);
        req  = r;
        lock = l;
        @(posedge clk);
        model_step(r, l);
        exp_q.push_back(model_out());
        cyc = cyc + 1;
        #2;
    endtask

    task automatic async_reset();
        #1;
        rst_n = 1'b0;
        #1;
        tests = tests + 1;
        if ({sel, grant, oe_en, busy} !== '0) begin
            failed = failed + 1;
            $display("FAIL async_reset: got sel=%b grant=%b oe=%b busy=%b, required all zero",
                     sel, grant, oe_en, busy);
        end
        exp_q.delete();
        model_reset();
        req = '0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [OW-1:0] e;
            logic [OW-1:0] a;
            e = exp_q.pop_front();
            a = {sel, grant, oe_en, busy};
            tests = tests + 1;
            if (a !== e) begin
                failed = failed + 1;
                $display("FAIL outputs cyc %0d: got sel=%b grant=%b oe=%b busy=%b, required sel=%b grant=%b oe=%b busy=%b",
                         cyc, a[OW-1 -: SW], a[N+1:2], a[1], a[0],
                         e[OW-1 -: SW], e[N+1:2], e[1], e[0]);
            end
        end
    end

    initial begin
        logic [N-1:0] r;
        logic         l;
        tests  = 0;
        failed = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        req    = '0;
        lock   = 1'b0;
        model_reset();

        #1;
        tests = tests + 1;
        if ({sel, grant, oe_en, busy} !== '0) begin
            failed = failed + 1;
            $display("FAIL reset_state: got sel=%b grant=%b oe=%b busy=%b, required all zero",
                     sel, grant, oe_en, busy);
        end
        #11;
        rst_n = 1'b1;

        // Single requester held: select after G+1 edges, grant after G+2.
        for (int i = 0; i < 6; i++) tick(6'b000001, 1'b0);
        // Two requesters: owner 0 releases, drain, then owner 2.
        for (int i = 0; i < 3; i++) tick(6'b000101, 1'b0);
        for (int i = 0; i < 8; i++) tick(6'b000100, 1'b0);
        // Reset while owning.
        async_reset();
        // Requester beyond the select width is never served.
        for (int i = 0; i < 12; i++) tick(6'b100000, 1'b0);
        // Winner withdraws during guard; pointer must still favour index 0.
        tick(6'b000001, 1'b0);
        tick(6'b000000, 1'b0);
        for (int i = 0; i < 6; i++) tick(6'b000011, 1'b0);
        for (int i = 0; i < 6; i++) tick(6'b000010, 1'b0);
        // Owner wraps around to index 0 from the top eligible slot.
        for (int i = 0; i < 6; i++) tick(6'b010001, 1'b0);
        for (int i = 0; i < 8; i++) tick(6'b000001, 1'b0);
        tick(6'b000000, 1'b0);
        tick(6'b000000, 1'b0);

        r = '0;
        l = 1'b0;
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
`ifdef PINMUX_LOCK_EN
            if ($urandom_range(0, 15) == 0) l = ~l;
`endif
            tick(r, l);
            if (c == 400) async_reset();
        end

        @(negedge clk);
        #1;
        tests = tests + 1;
        if (exp_q.size() != 0) begin
            failed = failed + 1;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pinmux_sel_ctrl.md
PINMUX_SEL_CTRL -- requirements
Module: pinmux_sel_ctrl

Interface
REQ-001 SHALL have parameter NUM_PERIPHERALS, default 4: number of requesters.
REQ-002 SHALL have parameter SEL_WIDTH, default 5: width of the pad-select vector, one bit per selectable peripheral.
REQ-003 SHALL have parameter GUARD_CYCLES, default 2, legal range >= 1: cycles during which the pad is undriven between owners.
REQ-004 SHALL have port i_clk, input, 1: single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port i_req, input, NUM_PERIPHERALS: level request per peripheral; held high to keep ownership.
REQ-007 SHALL have port o_grant, output, NUM_PERIPHERALS: one-hot current owner, or all zero.
REQ-008 SHALL have port o_sel, output, SEL_WIDTH: one-hot select driving the pad mux, or all zero.
REQ-009 SHALL have port o_oe_en, output, 1: pad output-enable gate, ANDed downstream with the muxed OE.
REQ-010 SHALL have port o_busy, output, 1: high in every state except IDLE.

Function
REQ-011 SHALL implement states IDLE, GUARD, SELECT, OWNED, DRAIN.
REQ-012 IDLE SHALL drive o_sel=0, o_grant=0, o_oe_en=0.
REQ-013 In IDLE with any eligible request, the block SHALL latch a round-robin winner, load the guard counter with GUARD_CYCLES-1, and enter GUARD.
REQ-014 A requester index >= SEL_WIDTH SHALL be ineligible and SHALL never be granted.
REQ-015 Round-robin priority SHALL start at index 0 after reset and SHALL move to winner+1 (mod NUM_PERIPHERALS) when OWNED is entered.
REQ-016 GUARD SHALL keep all outputs at 0 and decrement the counter; at count 0 it SHALL go to SELECT.
REQ-017 SELECT SHALL drive o_sel one-hot for the winner, with o_grant=0 and o_oe_en=0, for exactly one cycle; it SHALL then go to OWNED.
REQ-018 OWNED SHALL drive o_sel, o_grant one-hot for the winner, and o_oe_en=1.
REQ-019 Latency from the edge that samples a request in IDLE to o_grant high SHALL be GUARD_CYCLES+2 clocks.
REQ-020 In OWNED, when the owner's i_req is low, the block SHALL go to DRAIN.
REQ-021 DRAIN SHALL last one cycle with o_oe_en=0, o_grant=0 and o_sel held, then SHALL go to IDLE; OE therefore falls one cycle before the select changes (break-before-make).
REQ-022 If the winner's i_req drops during GUARD or SELECT, the block SHALL go to IDLE without granting, and the round-robin pointer SHALL be unchanged.
REQ-023 Requests from non-owners SHALL be ignored outside IDLE; no preemption.
REQ-024 o_sel and o_grant SHALL never have more than one bit set, and o_oe_en=1 SHALL imply o_sel≠0.

Reset
REQ-025 Asserting i_rst_n low SHALL asynchronously force IDLE, all outputs to 0, the counter to 0 and the round-robin pointer to 0, including mid-ownership.
REQ-026 After deassertion, the first request SHALL be sampled on the first rising edge.

Configuration
REQ-027 With PINMUX_LOCK_EN defined, the block SHALL add port i_lock, input, 1: in OWNED, lock high SHALL keep ownership regardless of i_req; in IDLE, lock high SHALL block new arbitration.
REQ-028 Without PINMUX_LOCK_EN, i_lock SHALL be absent and the behaviour SHALL equal i_lock=0.

Structure
REQ-029 Package pinmux_pkg SHALL hold the state enum and the default parameter constants.
REQ-030 The round-robin selection SHALL be sub-module pinmux_rr_arb: combinational, with inputs request, eligibility mask and pointer, and one-hot output.

Verification
REQ-031 Scenario: G=2, i_req=0001 held -> o_sel=00001 after 3 edges, o_grant=0001 and o_oe_en=1 after 4 edges.
REQ-032 Scenario: i_req=0101 in IDLE -> grant 0001; drop req0 -> DRAIN (oe=0, sel=00001), IDLE, GUARD 2, then grant 0100.
REQ-033 Scenario: NUM_PERIPHERALS=6, SEL_WIDTH=5, only i_req[5]=1 -> block stays IDLE, o_busy=0 indefinitely.
REQ-034 Scenario: winner drops req in GUARD -> IDLE, no grant pulse, pointer unchanged.
REQ-035 Scenario: i_rst_n low while OWNED -> all outputs 0 asynchronously, before the next edge.
REQ-036 Scenario: PINMUX_LOCK_EN, lock=1 in OWNED, owner drops req -> o_grant unchanged until lock=0, then DRAIN.
